// File: rtl/line_mem_pkg.sv
// Shared types for the line-granular memory responder: FSM states, word width and line typedef.
package line_mem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, GRANT} mem_state_t;

   localparam int unsigned WORD_W            = 32;
   localparam int unsigned DEF_LINE_ADDR_LEN = 3;

   function automatic int unsigned line_size(input int unsigned line_addr_len);
      return 32'd1 << line_addr_len;
   endfunction

   localparam int unsigned DEF_LINE_SIZE = line_size(DEF_LINE_ADDR_LEN);

   typedef logic [DEF_LINE_SIZE-1:0][WORD_W-1:0] line_t;

endpackage

// File: rtl/line_mem_array.sv
// Line-wide backing store: one synchronous write port, one combinational read port.
// Each line powers up holding word i = (line << LINE_ADDR_LEN) + i; contents are never reset.
module line_mem_array
   import line_mem_pkg::*;
#(
   parameter int unsigned LINE_ADDR_LEN = 3,
   parameter int unsigned ADDR_LEN      = 9,
   localparam int unsigned LS           = line_size(LINE_ADDR_LEN)
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [ADDR_LEN-1:0]          waddr,
   input  logic [LS-1:0][WORD_W-1:0]    wdata,
   input  logic [ADDR_LEN-1:0]          raddr,
   output logic [LS-1:0][WORD_W-1:0]    rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_LEN;

   typedef logic [LS-1:0][WORD_W-1:0] row_t;

   function automatic row_t init_row(input int unsigned a);
      row_t r;
      for (int unsigned i = 0; i < LS; i++) begin
         r[i] = WORD_W'((a << LINE_ADDR_LEN) + i);
      end
      return r;
   endfunction

   row_t rows [DEPTH];

   // One register row per line, each carrying its power-up pattern.
   for (genvar a = 0; a < DEPTH; a++) begin : g_row
      row_t row = init_row(a);

      always_ff @(posedge clk) begin
         if (we && (waddr == ADDR_LEN'(a))) begin
            row <= wdata;
         end
      end

      assign rows[a] = row;
   end

   assign rdata = rows[raddr];

endmodule

// File: rtl/line_mem_responder.sv
// Memory side of the cache<->memory line protocol: accepts one line op, waits LATENCY, pulses gnt.
// Optional LINE_MEM_STATS_EN adds saturating rd_cnt / wr_cnt / abort_cnt outputs.
module line_mem_responder
   import line_mem_pkg::*;
#(
   parameter int unsigned LINE_ADDR_LEN = 3,
   parameter int unsigned ADDR_LEN      = 9,
   parameter int unsigned LATENCY       = 8,
   localparam int unsigned LS           = line_size(LINE_ADDR_LEN)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_LEN-1:0]          addr,
   input  logic                         rd_req,
   output logic [LS-1:0][WORD_W-1:0]    rd_line,
   input  logic                         wr_req,
   input  logic [LS-1:0][WORD_W-1:0]    wr_line,
   output logic                         gnt
`ifdef LINE_MEM_STATS_EN
   ,
   output logic [31:0]                  rd_cnt,
   output logic [31:0]                  wr_cnt,
   output logic [31:0]                  abort_cnt
`endif
);

   localparam int unsigned CNT_W = 8;

   typedef logic [LS-1:0][WORD_W-1:0] row_t;

   mem_state_t          state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                op_wr, op_wr_d;
   logic [ADDR_LEN-1:0] lat_addr, lat_addr_d;
   row_t                lat_line, lat_line_d;
   row_t                rd_line_d;
   row_t                mem_rdata;
   logic                gnt_d;
   logic                commit;
   logic                req_live;

   // The op in flight stays alive only while its own request line is held.
   assign req_live = op_wr ? wr_req : rd_req;

   line_mem_array #(
      .LINE_ADDR_LEN (LINE_ADDR_LEN),
      .ADDR_LEN      (ADDR_LEN)
   ) u_array (
      .clk   (clk),
      .we    (commit && op_wr),
      .waddr (lat_addr),
      .wdata (lat_line),
      .raddr (lat_addr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         op_wr    <= 1'b0;
         lat_addr <= '0;
         lat_line <= '0;
         rd_line  <= '0;
         gnt      <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         op_wr    <= op_wr_d;
         lat_addr <= lat_addr_d;
         lat_line <= lat_line_d;
         rd_line  <= rd_line_d;
         gnt      <= gnt_d;
      end
   end

   // Next-state and registered-output logic; write wins when both requests are high.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      op_wr_d    = op_wr;
      lat_addr_d = lat_addr;
      lat_line_d = lat_line;
      rd_line_d  = rd_line;
      gnt_d      = 1'b0;
      commit     = 1'b0;

      case (state)
         IDLE: begin
            if (wr_req || rd_req) begin
               op_wr_d    = wr_req;
               lat_addr_d = addr;
               lat_line_d = wr_line;
               cnt_d      = CNT_W'(LATENCY - 1);
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (!req_live) begin
               state_d = IDLE;
            end else if (cnt == '0) begin
               commit  = 1'b1;
               gnt_d   = 1'b1;
               state_d = GRANT;
               if (!op_wr) begin
                  rd_line_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         GRANT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef LINE_MEM_STATS_EN
   logic abort_c;

   assign abort_c = (state == BUSY) && !req_live;

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         abort_cnt <= '0;
      end else begin
         if (commit && !op_wr && (rd_cnt != '1)) begin
            rd_cnt <= rd_cnt + 32'd1;
         end
         if (commit && op_wr && (wr_cnt != '1)) begin
            wr_cnt <= wr_cnt + 32'd1;
         end
         if (abort_c && (abort_cnt != '1)) begin
            abort_cnt <= abort_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: LATENCY=8 and LATENCY=1 instances, gnt-driven monitor.
module tb_line_mem_responder;
   import line_mem_pkg::*;

   localparam int unsigned LAT [2] = '{8, 1};

   typedef struct {
      int    cyc;
      line_t rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [8:0] addr_s    [2];
   logic       rd_req_s  [2];
   logic       wr_req_s  [2];
   logic       gnt_s     [2];
   line_t      rd_line_s [2];
   line_t      wr_line_s [2];
`ifdef LINE_MEM_STATS_EN
   logic [31:0] rd_cnt_s [2];
   logic [31:0] wr_cnt_s [2];
   logic [31:0] ab_cnt_s [2];
`endif

   exp_t        q0 [$];
   exp_t        q1 [$];
   int unsigned n_rd [2];
   int unsigned n_wr [2];
   int unsigned n_ab [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      line_mem_responder #(
         .LINE_ADDR_LEN (3),
         .ADDR_LEN      (9),
         .LATENCY       (LAT[g])
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .addr      (addr_s[g]),
         .rd_req    (rd_req_s[g]),
         .rd_line   (rd_line_s[g]),
         .wr_req    (wr_req_s[g]),
         .wr_line   (wr_line_s[g]),
         .gnt       (gnt_s[g])
`ifdef LINE_MEM_STATS_EN
         ,
         .rd_cnt    (rd_cnt_s[g]),
         .wr_cnt    (wr_cnt_s[g]),
         .abort_cnt (ab_cnt_s[g])
`endif
      );
   end

   function automatic line_t pat(input int a);
      line_t r;
      for (int i = 0; i < 8; i++) r[i] = 32'((a << 3) + i);
      return r;
   endfunction

   function automatic line_t seq(input int base);
      line_t r;
      for (int i = 0; i < 8; i++) r[i] = 32'(base + i);
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic mon(input int s);
      exp_t e;
      if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL unexpected_gnt: dut%0d got gnt=1 expected none (cycle %0d)", s, cyc);
         return;
      end
      if (s == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("gnt_cycle_dut%0d", s), 256'(cyc), 256'(e.cyc));
      chk($sformatf("rd_line_dut%0d", s), rd_line_s[s], e.rd);
   endtask

   always @(negedge clk) begin
      if (gnt_s[0]) mon(0);
      if (gnt_s[1]) mon(1);
   end

   // Issue one op right after an edge; scrambles addr/wr_line after accept, waits for gnt.
   task automatic run_op(input int s, input bit is_wr, input bit both, input int a,
                         input line_t wd, input int hold, input line_t exp_rd);
      exp_t e;
      bit   seen;
      addr_s[s]    = 9'(a);
      wr_line_s[s] = wd;
      wr_req_s[s]  = is_wr;
      rd_req_s[s]  = !is_wr || both;
      e.cyc = cyc + 1 + int'(LAT[s]);
      e.rd  = exp_rd;
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
      if (is_wr) n_wr[s]++;
      else       n_rd[s]++;
      seen = 1'b0;
      for (int n = 0; n < int'(LAT[s]) + 4 && !seen; n++) begin
         @(posedge clk);
         #1;
         if (n == 0) begin
            addr_s[s]    = 9'(a ^ 1);
            wr_line_s[s] = ~wd;
         end
         seen = gnt_s[s];
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL gnt_timeout: dut%0d got no gnt expected one (cycle %0d)", s, cyc);
      end
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      wr_req_s[s] = 1'b0;
      rd_req_s[s] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_abort(input int s, input int a, input line_t wd, input int edges);
      addr_s[s]    = 9'(a);
      wr_line_s[s] = wd;
      wr_req_s[s]  = 1'b1;
      repeat (edges) begin
         @(posedge clk);
         #1;
      end
      wr_req_s[s] = 1'b0;
      n_ab[s]++;
      repeat (int'(LAT[s]) + 4) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         addr_s[s] = '0; rd_req_s[s] = 1'b0; wr_req_s[s] = 1'b0; wr_line_s[s] = '0;
         n_rd[s] = 0; n_wr[s] = 0; n_ab[s] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_gnt", 256'(gnt_s[0]), 256'(0));
      chk("reset_rd_line", rd_line_s[0], '0);
      chk("reset_rd_line_dut1", rd_line_s[1], '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op(0, 1'b0, 1'b0, 5, '0, 0, pat(5));
      run_op(0, 1'b1, 1'b0, 5, seq(32'hA0), 0, pat(5));
      run_op(0, 1'b0, 1'b0, 5, '0, 0, seq(32'hA0));
      run_op(0, 1'b0, 1'b0, 6, '0, 0, pat(6));
      run_op(0, 1'b0, 1'b0, 7, '0, 1, pat(7));
      run_op(0, 1'b0, 1'b0, 2, '0, 0, pat(2));
      run_op(0, 1'b1, 1'b1, 3, seq(32'hB0), 0, pat(2));
      run_op(0, 1'b0, 1'b0, 3, '0, 0, seq(32'hB0));

      run_abort(0, 4, seq(32'hC0), 4);
`ifdef LINE_MEM_STATS_EN
      chk("abort_cnt", 256'(ab_cnt_s[0]), 256'(n_ab[0]));
`endif
      run_op(0, 1'b0, 1'b0, 4, '0, 0, pat(4));

      // Reset in the middle of a write: nothing may commit.
      addr_s[0]    = 9'd4;
      wr_line_s[0] = seq(32'hD0);
      wr_req_s[0]  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      chk("midrst_gnt", 256'(gnt_s[0]), 256'(0));
      chk("midrst_rd_line", rd_line_s[0], '0);
      #2;
      rst = 1'b0;
      wr_req_s[0] = 1'b0;
      for (int s = 0; s < 2; s++) begin
         n_rd[s] = 0; n_wr[s] = 0; n_ab[s] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      run_op(0, 1'b0, 1'b0, 4, '0, 0, pat(4));

      run_op(0, 1'b1, 1'b0, 511, seq(32'hF0), 0, pat(4));
      run_op(0, 1'b0, 1'b0, 511, '0, 0, seq(32'hF0));
      run_op(0, 1'b0, 1'b0, 0, '0, 0, pat(0));

      run_op(1, 1'b1, 1'b0, 10, seq(32'hE0), 0, '0);
      run_op(1, 1'b0, 1'b0, 10, '0, 0, seq(32'hE0));
      run_op(1, 1'b0, 1'b0, 0, '0, 0, pat(0));

      repeat (5) @(posedge clk);
      #1;
`ifdef LINE_MEM_STATS_EN
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("rd_cnt_dut%0d", s), 256'(rd_cnt_s[s]), 256'(n_rd[s]));
         chk($sformatf("wr_cnt_dut%0d", s), 256'(wr_cnt_s[s]), 256'(n_wr[s]));
         chk($sformatf("abort_cnt_dut%0d", s), 256'(ab_cnt_s[s]), 256'(n_ab[s]));
      end
`endif
      chk("pending_dut0", 256'(q0.size()), 256'(0));
      chk("pending_dut1", 256'(q1.size()), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
